// File: rtl/ser16_tx.sv
// ser16_tx: buffers one WIDTH-bit word in a holding register and sends it
// MSB first as an asynchronous serial frame: start bit, data bits, optional
// even parity bit, then stop bit. The line idles high. While one frame is on
// the line, a single further word can be queued in the holding register, so
// frames can run back-to-back with no idle gap.
module ser16_tx #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             take_hold;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic             par;
  logic             par_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic             tx_nxt;
  logic             bit_end;

  // The holding register is only ever written while it is empty, so the
  // transfer into the shifter and a new load can never collide.
  assign ready = !hold_valid;
  assign busy  = (state != IDLE);
  assign done  = (state == STOP) && (cyc_cnt == CYC_LAST);
  assign bit_end = (cyc_cnt == CYC_LAST);

  // Holding register and its sticky overrun flag; a load while full is dropped.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take_hold) begin
        hold_valid <= 1'b0;
      end else if (load && !hold_valid) begin
        hold       <= data_in;
        hold_valid <= 1'b1;
      end
      if (load && hold_valid) begin
        overrun <= 1'b1;
      end
    end
  end

  // Frame state, shifter, counters and the registered serial line.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state   <= IDLE;
      shift   <= '0;
      par     <= 1'b0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state logic; tx is computed from the next state so the line flop
  // changes on the same edge as the state it belongs to.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    par_nxt   = par;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    take_hold = 1'b0;
    tx_nxt    = 1'b1;

    case (state)
      IDLE: begin
        cyc_nxt = '0;
        bit_nxt = '0;
        if (hold_valid) begin
          take_hold = 1'b1;
          shift_nxt = hold;
          par_nxt   = ^hold;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cyc_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            shift_nxt = {shift[WIDTH-2:0], 1'b0};
          end
        end else begin
          cyc_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cyc_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cyc_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_nxt = '0;
          if (hold_valid) begin
            take_hold = 1'b1;
            shift_nxt = hold;
            par_nxt   = ^hold;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cyc_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[WIDTH-1];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ser16_tx.sv
// tb_ser16_tx: drives words into ser16_tx, a line monitor decodes every frame
// cycle by cycle and compares it against a scoreboard of expected words.
module tb_ser16_tx;

  localparam int WIDTH      = 16;
  localparam int CPB        = 4;
  localparam int FRAME_BITS = 2 + WIDTH + 1;

  logic             clk;
  logic             rest;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             tx;
  logic             busy;
  logic             done;
  logic             overrun;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             parity;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[6];

  int total = 0;
  int bad = 0;
  int cyc_num = 0;
  int done_count = 0;
  int last_done_cyc = -1000;
  int start_gap = 0;
  logic abort_req = 1'b0;

  ser16_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
    .clk(clk),
    .rest(rest),
    .load(load),
    .data_in(data_in),
    .ready(ready),
    .tx(tx),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cycle index, stable at every falling edge
  always @(posedge clk) cyc_num++;

  // done pulse bookkeeping
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      last_done_cyc = cyc_num;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // called at a falling edge: drives one load cycle, returns at the next falling edge
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic expect_accept);
    checkOutput("ready_at_load", {31'd0, ready}, {31'd0, expect_accept});
    load    = 1'b1;
    data_in = word;
    if (expect_accept) sb.push_back('{word, ^word});
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400; n++) begin
      if (!busy && ready) break;
      @(negedge clk);
    end
    if (n >= 400) begin
      bad++;
      total++;
      $display("[TB] FAIL idle_timeout: got busy=%0b expected busy=0", busy);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    for (n = 0; n < 400; n++) begin
      if (done_count >= target) break;
      @(negedge clk);
    end
    if (n >= 400) begin
      bad++;
      total++;
      $display("[TB] FAIL done_timeout: got %0d expected %0d", done_count, target);
    end
  endtask

  // decodes one frame, starting at the first falling edge where tx is low
  task automatic capture_frame();
    logic bits[FRAME_BITS];
    logic [WIDTH-1:0] word;
    int errs;
    vec_t exp_v;
    errs = 0;
    start_gap = cyc_num - last_done_cyc;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (abort_req) return;
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) errs++;
        if (busy !== 1'b1) errs++;
        if (done !== ((b == FRAME_BITS - 1) && (c == CPB - 1))) errs++;
      end
    end
    for (int i = 0; i < WIDTH; i++) word[WIDTH-1-i] = bits[1+i];
    if (bits[0] !== 1'b0) errs++;
    if (bits[FRAME_BITS-1] !== 1'b1) errs++;
    checkOutput("frame_timing", errs, 0);
    if (sb.size() == 0) begin
      bad++;
      total++;
      $display("[TB] FAIL unexpected_frame: got word %0h expected no frame", word);
    end else begin
      exp_v = sb.pop_front();
      checkOutput("frame_word", {16'd0, word}, {16'd0, exp_v.word});
      checkOutput("frame_parity", {31'd0, bits[FRAME_BITS-2]}, {31'd0, exp_v.parity});
    end
  endtask

  // line monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!abort_req && rest === 1'b0 && tx === 1'b0) capture_frame();
    end
  end

  initial begin
    int cnt;
    int d0;
    vecs[0] = '{16'h00FF, 1'b0};
    vecs[1] = '{16'h1234, 1'b1};
    vecs[2] = '{16'h8000, 1'b1};
    vecs[3] = '{16'hFFFF, 1'b0};
    vecs[4] = '{16'h7FFF, 1'b1};
    vecs[5] = '{16'hC3A5, 1'b0};

    // reset while the clock runs
    load = 1'b0;
    data_in = '0;
    rest = 1'b0;
    #1 rest = 1'b1;
    #2 checkOutput("reset_async", {27'd0, tx, ready, busy, done, overrun}, 32'b11000);
    #3 rest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_hold", {27'd0, tx, ready, busy, done, overrun}, 32'b11000);
    end

    // single word F0F0 with precise start timing
    $display("[TB] single word F0F0");
    applyStimulus(16'hF0F0, 1'b1);
    checkOutput("after_load", {29'd0, ready, busy, tx}, 32'b001);
    @(negedge clk);
    checkOutput("frame_start", {29'd0, ready, busy, tx}, 32'b110);
    wait_idle();

    // word 0001, busy window length
    $display("[TB] word 0001 busy length");
    @(negedge clk);
    applyStimulus(16'h0001, 1'b1);
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    checkOutput("busy_cycles", cnt, 76);
    wait_idle();

    // table-driven words
    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      checkOutput("table_parity_model", {31'd0, ^vecs[i].word}, {31'd0, vecs[i].parity});
      d0 = done_count;
      @(negedge clk);
      applyStimulus(vecs[i].word, 1'b1);
      wait_done(d0 + 1);
      wait_idle();
    end

    // back-to-back frames
    $display("[TB] back-to-back");
    d0 = done_count;
    @(negedge clk);
    applyStimulus(16'hAAAA, 1'b1);
    repeat (20) @(negedge clk);
    applyStimulus(16'h5555, 1'b1);
    wait_done(d0 + 2);
    wait_idle();
    repeat (3) @(negedge clk);
    checkOutput("b2b_done_count", done_count - d0, 2);
    checkOutput("b2b_gap", start_gap, 1);

    // overrun
    $display("[TB] overrun");
    d0 = done_count;
    @(negedge clk);
    applyStimulus(16'h1234, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
    applyStimulus(16'h0F0F, 1'b1);
    wait_done(d0 + 2);
    wait_idle();
    checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);

    // reset during data bit 5
    $display("[TB] reset mid-frame");
    @(negedge clk);
    applyStimulus(16'hF0F0, 1'b1);
    repeat (26) @(negedge clk);
    abort_req = 1'b1;
    #1 rest = 1'b1;
    #1 checkOutput("midframe_reset", {28'd0, tx, busy, ready, overrun}, 32'b1010);
    #1 rest = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    abort_req = 1'b0;
    checkOutput("post_reset_idle", {29'd0, tx, busy, ready}, 32'b101);
    d0 = done_count;
    applyStimulus(16'h00FF, 1'b1);
    wait_done(d0 + 1);
    wait_idle();
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser16_tx.md
Name: ser16_tx

Overview:
- Downstream consumer of the 16-bit registered datapath word (data_out of the clock-enabled invert/hold register).
- Accepts one word per load strobe and buffers it in a 1-deep holding register.
- Transmits each word serially on a single line as an asynchronous frame: start bit, data bits MSB first, optional even parity bit, stop bit.
- Output line drives the board-level serial link/probe pin.

Parameters:
- WIDTH, 16: data word width in bits.
- CLKS_PER_BIT, 4: clk cycles per serial bit, minimum 1.
- PARITY_EN, 1: 1 = append an even parity bit; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rest  input  1  asynchronous, active-high reset.
- load  input  1  word-valid strobe; data_in is captured when load=1 and ready=1.
- data_in  input  WIDTH  word to transmit; normally connected to the upstream register's data_out.
- ready  output  1  holding register empty; a load is accepted this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse at the end of each stop bit.
- overrun  output  1  sticky flag: a load arrived while ready=0.

Behaviour:
- Reset (rest=1, asynchronous): tx=1, ready=1, busy=0, done=0, overrun=0. Holding register is emptied, FSM goes to IDLE, bit and cycle counters clear to 0.
- Reset mid-frame: the frame is abandoned immediately and tx returns to 1 without waiting for a clock edge. The first load after reset release is accepted normally.
- Holding register:
  - On load && ready at an edge: hold <= data_in, hold_valid <= 1.
  - ready = !hold_valid, registered.
  - On load && !ready: the word is discarded and overrun <= 1. overrun is cleared only by rest.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If hold_valid: shift register <= hold, hold_valid <= 0, parity <= XOR of the hold bits, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[WIDTH-1]. The register shifts left every CLKS_PER_BIT cycles. After WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: tx = XOR of the data bits (even parity), held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle done=1 for exactly one clk. If hold_valid, go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
- Timing:
  - tx is a registered output.
  - For a load sampled at edge E while IDLE with the hold register empty: hold_valid rises at E, the IDLE->START transition happens at E+1, and tx goes low after edge E+1.
  - Frame length = (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles; 76 at the defaults.
- A new word may be loaded at any time while a frame is in flight, as long as ready=1. The in-flight shift register is never disturbed by a load.
- A hold-to-shift transfer and a new load can never occur on the same edge, because ready=0 whenever hold_valid=1.
- busy is derived from the registered state and rises in the same cycle tx first goes low.
- Cycle counter wraps from CLKS_PER_BIT-1 to 0. Bit counter runs 0..WIDTH-1 and clears on leaving DATA.

Test Plan:
- Reset check: assert rest for 5 ns with clk running -> tx=1, ready=1, busy=0, done=0, overrun=0; all values hold while load=0.
- Single word 16'hF0F0: load 1 cycle. Required tx sequence, 4 cycles per bit:
  - start bit 0;
  - data bits 1111000011110000;
  - parity 0 (eight ones);
  - stop bit 1.
  - done pulses once at cycle 76 of the frame, and ready=1 again by 2 cycles after load.
- Word 16'h0001 -> last data bit 1, parity bit 1, busy high for exactly 76 cycles.
- Back-to-back: load 16'hAAAA, then load 16'h5555 during its DATA state -> second start bit begins on the cycle immediately after the first stop bit ends (no idle high gap); done pulses twice.
- Overrun: load 16'h1234, then while ready=0 load 16'hFFFF -> overrun=1 and stays 1. Only 16'h1234 (plus any word loaded after ready returns) is transmitted; 16'hFFFF never appears on tx.
- Reset mid-frame: assert rest during data bit 5 of 16'hF0F0 -> tx=1 with no clk edge needed, busy=0, ready=1. After release, load 16'h00FF -> a complete, correct frame with parity 0.
